lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the single-port 32-bit word RAM.
- Accepts RV64 byte-addressed loads and stores of size B/H/W/D from the memory stage.
- Converts each request into 32-bit word reads and writes on the RAM port, which has a combinational read and a clocked write.
- Handles byte/halfword stores by read-modify-write, doublewords as two word accesses, and load sign/zero extension.

Parameters:
- N, 20, RAM word-address width; RAM holds 2^N 32-bit words.
- XLEN, 64, core data and address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0=B, 1=H, 2=W, 3=D.
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU); ignored for D and stores.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range request; valid with resp_valid.
- ram_we  out  1  RAM write enable.
- ram_adr  out  N  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, combinational from ram_adr.

Behaviour:
- Reset: state=IDLE. The captured request register, lo/hi data registers, resp_rdata and resp_err are all 0. While rst=1, req_ready=0, resp_valid=0 and ram_we=0; ram_we is gated by !rst so a write state cannot write during the reset cycle. Reset mid-operation abandons the request with no response and no further RAM writes.
- Handshake: req_ready=1 only in IDLE and not in rst. A request is accepted when req_valid && req_ready, and all req_* fields are captured. One outstanding request at a time.
- Word address: wadr = addr[N+1:2]. Byte offset: off = addr[1:0]. Memory is little-endian.
- Error:
  - Misaligned: H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0.
  - Out of range: addr[XLEN-1:N+2]!=0.
  - Either condition goes to RESP with err=1 and no RAM access.
- Because a D access is 8-aligned, wadr is even and wadr+1 never wraps.
- FSM states: IDLE, RD_LO, RD_HI, RMW_RD, WR_LO, WR_HI, RESP.
- IDLE on accept:
  - error -> RESP.
  - load -> RD_LO.
  - store B/H -> RMW_RD.
  - store W/D -> WR_LO.
- RD_LO: ram_adr=wadr, ram_we=0; lo<=ram_dout. Next state is RD_HI if D, else RESP.
- RD_HI: ram_adr=wadr+1; hi<=ram_dout; next state RESP.
- RMW_RD: ram_adr=wadr; the merged word is registered: ram_dout with byte(s) at off replaced by wdata[7:0] (B) or wdata[15:0] (H). Next state WR_LO.
- WR_LO: ram_we=1, ram_adr=wadr. ram_din = merged (B/H) or wdata[31:0] (W/D). Next state is WR_HI if D, else RESP.
- WR_HI: ram_we=1, ram_adr=wadr+1, ram_din=wdata[63:32]; next state RESP.
- RESP: resp_valid=1 for exactly one cycle; next state IDLE. req_ready returns to 1 the following cycle.
- Load result:
  - B: lo byte at off, sign/zero-extended.
  - H: halfword at off[1], sign/zero-extended.
  - W: lo, sign/zero-extended.
  - D: {hi,lo}.
- resp_rdata and resp_err are held stable from RESP until the next accept.
- Outside write states ram_we=0, and ram_adr/ram_din are don't-care but must not X-propagate (drive wadr / 0).
- Latency from accept cycle T to resp_valid:
  - error T+1.
  - LB/LH/LW and SW: T+2.
  - LD, SB, SH and SD: T+3.

Decomposition:
- Package lsu_pkg holds: size_e enum (SZ_B, SZ_H, SZ_W, SZ_D), state_e enum, and the RAM data-width constant 32.
- One combinational sub-module, lsu_align, holds load extract/extend (off, size, unsigned, lo, hi -> rdata) and store byte merge (old word, off, size, wdata -> merged word).
- The FSM stays in lsu_mem_ctrl.

Test Plan:
- SD addr 0x4000, wdata 0x1122334455667788 -> word 0x1000 = 0x55667788 and 0x1001 = 0x11223344 written on consecutive cycles; resp_valid at T+3, err=0. Then LD 0x4000 -> rdata 0x1122334455667788 at T+3.
- Word 0x1000 = 0xAABBCCDD; SB addr 0x4002 wdata 0x5A -> word becomes 0xAA5ACCDD, exactly one ram_we cycle. Then LB 0x4003 -> 0xFFFFFFFFFFFFFFAA; LBU 0x4003 -> 0x00000000000000AA.
- Word 0x1000 = 0x8000_1234: LH 0x4002 -> 0xFFFFFFFFFFFF8000; LW 0x4000 -> 0xFFFFFFFF80001234; LWU 0x4000 -> 0x0000000080001234.
- LW 0x4001, SD 0x4004, and LB with addr bit N+2 set -> each gives resp_valid at T+1 with err=1, rdata=0, and no ram_we.
- Assert rst during WR_HI of an SD -> ram_we=0 in that cycle, word wadr+1 unchanged, no resp_valid, req_ready=1 the cycle after rst drops.
- Back-to-back requests with req_valid held high -> req_ready=0 from accept through RESP, the second request is accepted the cycle after RESP, and no request is lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store controller: access sizes, FSM states, RAM word width.
package lsu_pkg;

    localparam int RAM_DW = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LO  = 3'd1,
        RD_HI  = 3'd2,
        RMW_RD = 3'd3,
        WR_LO  = 3'd4,
        WR_HI  = 3'd5,
        RESP   = 3'd6
    } state_e;

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: load byte/half/word extraction with sign/zero extension,
// and byte/half merge of store data into an old RAM word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    input  logic [RAM_DW-1:0] lo_i,
    input  logic [RAM_DW-1:0] hi_i,
    input  logic [RAM_DW-1:0] old_i,
    input  logic [15:0]       wdata_i,
    output logic [XLEN-1:0]   rdata_o,
    output logic [RAM_DW-1:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sx;

    always_comb begin
        byte_v   = lo_i[{off_i, 3'b000} +: 8];
        half_v   = off_i[1] ? lo_i[31:16] : lo_i[15:0];
        sx       = ~uns_i;
        rdata_o  = '0;
        merged_o = old_i;
        case (size_e'(size_i))
            SZ_B: begin
                rdata_o = {{(XLEN-8){sx & byte_v[7]}}, byte_v};
                merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                rdata_o = {{(XLEN-16){sx & half_v[15]}}, half_v};
                merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i;
            end
            SZ_W:    rdata_o = {{(XLEN-32){sx & lo_i[31]}}, lo_i};
            default: rdata_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a single-port 32-bit RAM (combinational read, clocked write).
// Latency accept->resp: error 1, LB/LH/LW/SW 2, LD/SB/SH/SD 3; one request outstanding, req_ready only in IDLE.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int N    = 20,
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              ram_we,
    output logic [N-1:0]      ram_adr,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout
);

    state_e            state_q, state_d;
    logic              we_q, uns_q;
    logic [1:0]        size_q, off_q;
    logic [N-1:0]      wadr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [RAM_DW-1:0] lo_q, lo_d, hi_q, hi_d, merged_q, merged_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept, misalign, out_of_range, req_err, wr_en;
    logic [RAM_DW-1:0] al_lo, al_hi, al_merged;
    logic [XLEN-1:0]   al_rdata;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP) && !rst;
    assign ram_we     = wr_en && !rst;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        misalign = 1'b0;
        case (size_e'(req_size))
            SZ_H:    misalign = req_addr[0];
            SZ_W:    misalign = |req_addr[1:0];
            SZ_D:    misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    assign out_of_range = |req_addr[XLEN-1:N+2];
    assign req_err      = misalign || out_of_range;

    // Feed the extractor with the word being read this cycle so the response register loads on entry to RESP.
    assign al_lo = (state_q == RD_LO) ? ram_dout : lo_q;
    assign al_hi = (state_q == RD_HI) ? ram_dout : hi_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .off_i    (off_q),
        .size_i   (size_q),
        .uns_i    (uns_q),
        .lo_i     (al_lo),
        .hi_i     (al_hi),
        .old_i    (ram_dout),
        .wdata_i  (wdata_q[15:0]),
        .rdata_o  (al_rdata),
        .merged_o (al_merged)
    );

    always_comb begin
        state_d      = state_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        merged_d     = merged_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        wr_en        = 1'b0;
        ram_adr      = wadr_q;
        ram_din      = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    resp_rdata_d = '0;
                    resp_err_d   = req_err;
                    if (req_err)                                  state_d = RESP;
                    else if (!req_we)                             state_d = RD_LO;
                    else if (req_size == SZ_B || req_size == SZ_H) state_d = RMW_RD;
                    else                                          state_d = WR_LO;
                end
            end
            RD_LO: begin
                lo_d = ram_dout;
                if (size_q == SZ_D) begin
                    state_d = RD_HI;
                end else begin
                    resp_rdata_d = al_rdata;
                    state_d      = RESP;
                end
            end
            RD_HI: begin
                ram_adr      = wadr_q + N'(1);
                hi_d         = ram_dout;
                resp_rdata_d = al_rdata;
                state_d      = RESP;
            end
            RMW_RD: begin
                merged_d = al_merged;
                state_d  = WR_LO;
            end
            WR_LO: begin
                wr_en   = 1'b1;
                ram_din = (size_q == SZ_B || size_q == SZ_H) ? merged_q : wdata_q[31:0];
                state_d = (size_q == SZ_D) ? WR_HI : RESP;
            end
            WR_HI: begin
                wr_en   = 1'b1;
                ram_adr = wadr_q + N'(1);
                ram_din = wdata_q[63:32];
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            wadr_q       <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            merged_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            merged_q     <= merged_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                off_q   <= req_addr[1:0];
                wadr_q  <= req_addr[N+1:2];
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table through a response scoreboard, plus reset-mid-store
// and back-to-back handshake sequences.
module tb_lsu_mem_ctrl;

    localparam int N    = 20;
    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [XLEN-1:0]   req_addr, req_wdata;
    logic              resp_valid, resp_err;
    logic [XLEN-1:0]   resp_rdata;
    logic              ram_we;
    logic [N-1:0]      ram_adr;
    logic [31:0]       ram_din, ram_dout;

    logic [31:0] mem [0:(1<<N)-1];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.N(N), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_we       (ram_we),
        .ram_adr      (ram_adr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    assign ram_dout = mem[ram_adr];
    always @(posedge clk) if (ram_we) mem[ram_adr] <= ram_din;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
        int          lat;
        int          we0;
        int          wes;
        int          id;
    } exp_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
        int          wecnt;
    } rsp_t;

    int   cyc = 0;
    int   we_cnt = 0;
    rsp_t rsp_q[$];
    exp_t exp_q[$];
    int   rd_idx = 0;
    int   n_issued = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt [19];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) we_cnt = we_cnt + 1;
        if (resp_valid) rsp_q.push_back('{resp_rdata, resp_err, cyc, we_cnt});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [63:0] a, input logic [63:0] wd,
                                input logic [63:0] rd, input logic e, input int lat, input int wes);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.err = e; v.lat = lat; v.wes = wes;
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input vec_t v, input int id, input bit hold, output int acc);
        int t;
        t = 0;
        acc = -1;
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk($sformatf("accept_timeout[%0d]", id), 64'd0, 64'd1);
        end else begin
            acc = cyc;
            exp_q.push_back('{v.rdata, v.err, cyc, v.lat, we_cnt, v.wes, id});
            n_issued++;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        exp_t e;
        rsp_t r;
        int   t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = 0;
            while (rsp_q.size() <= rd_idx && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (rsp_q.size() <= rd_idx) begin
                chk($sformatf("resp_timeout[%0d]", e.id), 64'd0, 64'd1);
            end else begin
                r = rsp_q[rd_idx];
                rd_idx++;
                chk($sformatf("rdata[%0d]", e.id), r.rdata, e.rdata);
                chk($sformatf("err[%0d]", e.id), 64'(r.err), 64'(e.err));
                chk($sformatf("latency[%0d]", e.id), 64'(r.cyc - e.acc), 64'(e.lat));
                chk($sformatf("ram_we_cycles[%0d]", e.id), 64'(r.wecnt - e.we0), 64'(e.wes));
            end
        end
    endtask

    initial begin
        int acc_a, acc_b, resp_a;

        //          we    size  uns   addr           wdata                   rdata                   err  lat wes
        vt[0]  = mk(1'b1, 2'd3, 1'b0, 64'h4000,      64'h1122334455667788,   64'h0,                  1'b0, 3, 2);
        vt[1]  = mk(1'b0, 2'd3, 1'b0, 64'h4000,      64'h0,                  64'h1122334455667788,   1'b0, 3, 0);
        vt[2]  = mk(1'b1, 2'd2, 1'b0, 64'h4000,      64'hAABBCCDD,           64'h0,                  1'b0, 2, 1);
        vt[3]  = mk(1'b1, 2'd0, 1'b0, 64'h4002,      64'h5A,                 64'h0,                  1'b0, 3, 1);
        vt[4]  = mk(1'b0, 2'd0, 1'b0, 64'h4003,      64'h0,                  64'hFFFFFFFFFFFFFFAA,   1'b0, 2, 0);
        vt[5]  = mk(1'b0, 2'd0, 1'b1, 64'h4003,      64'h0,                  64'h00000000000000AA,   1'b0, 2, 0);
        vt[6]  = mk(1'b0, 2'd2, 1'b0, 64'h4000,      64'h0,                  64'hFFFFFFFFAA5ACCDD,   1'b0, 2, 0);
        vt[7]  = mk(1'b1, 2'd2, 1'b0, 64'h4000,      64'h80001234,           64'h0,                  1'b0, 2, 1);
        vt[8]  = mk(1'b0, 2'd1, 1'b0, 64'h4002,      64'h0,                  64'hFFFFFFFFFFFF8000,   1'b0, 2, 0);
        vt[9]  = mk(1'b0, 2'd2, 1'b0, 64'h4000,      64'h0,                  64'hFFFFFFFF80001234,   1'b0, 2, 0);
        vt[10] = mk(1'b0, 2'd2, 1'b1, 64'h4000,      64'h0,                  64'h0000000080001234,   1'b0, 2, 0);
        vt[11] = mk(1'b0, 2'd2, 1'b0, 64'h4001,      64'h0,                  64'h0,                  1'b1, 1, 0);
        vt[12] = mk(1'b1, 2'd3, 1'b0, 64'h4004,      64'hFFFFFFFFFFFFFFFF,   64'h0,                  1'b1, 1, 0);
        vt[13] = mk(1'b0, 2'd0, 1'b0, 64'h400000,    64'h0,                  64'h0,                  1'b1, 1, 0);
        vt[14] = mk(1'b1, 2'd1, 1'b0, 64'h4006,      64'hBEEF,               64'h0,                  1'b0, 3, 1);
        vt[15] = mk(1'b0, 2'd1, 1'b1, 64'h4006,      64'h0,                  64'h000000000000BEEF,   1'b0, 2, 0);
        vt[16] = mk(1'b0, 2'd1, 1'b0, 64'h4006,      64'h0,                  64'hFFFFFFFFFFFFBEEF,   1'b0, 2, 0);
        vt[17] = mk(1'b0, 2'd3, 1'b0, 64'h4000,      64'h0,                  64'hBEEF334480001234,   1'b0, 3, 0);
        vt[18] = mk(1'b1, 2'd2, 1'b0, 64'h400C,      64'hDEADBEEF,           64'h0,                  1'b0, 2, 1);

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_ram_we", 64'(ram_we), 64'd0);
        chk("reset_resp_rdata", resp_rdata, 64'd0);
        chk("reset_resp_err", 64'(resp_err), 64'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            issue(vt[i], i, 1'b0, acc_a);
            drain();
            if (i == 0) begin
                chk("mem_sd_lo", 64'(mem[20'h1000]), 64'h55667788);
                chk("mem_sd_hi", 64'(mem[20'h1001]), 64'h11223344);
            end
            if (i == 3) chk("mem_sb_merge", 64'(mem[20'h1000]), 64'hAA5ACCDD);
            if (i == 14) chk("mem_sh_merge", 64'(mem[20'h1001]), 64'hBEEF3344);
        end

        // Back-to-back with req_valid held high.
        issue(vt[17], 100, 1'b1, acc_a);
        issue(mk(1'b0, 2'd0, 1'b0, 64'h4007, 64'h0, 64'hFFFFFFFFFFFFFFBE, 1'b0, 2, 0), 101, 1'b0, acc_b);
        resp_a = (rsp_q.size() > rd_idx) ? rsp_q[rd_idx].cyc : -1;
        drain();
        chk("b2b_accept_after_resp", 64'(acc_b), 64'(resp_a + 1));

        // Reset asserted during WR_HI of an SD.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
        req_addr = 64'h4008; req_wdata = 64'hCAFEF00D12345678;
        chk("rst_pre_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wr_hi_ram_we", 64'(ram_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 64'(req_ready), 64'd1);
        repeat (4) @(negedge clk);
        chk("rst_no_resp", 64'(rsp_q.size()), 64'(rd_idx));
        chk("rst_mem_lo_written", 64'(mem[20'h1002]), 64'h12345678);
        chk("rst_mem_hi_unchanged", 64'(mem[20'h1003]), 64'hDEADBEEF);
        chk("rst_resp_rdata_cleared", resp_rdata, 64'd0);

        chk("resp_count", 64'(rsp_q.size()), 64'(n_issued));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
